// File: rtl/mips_ctrl_fsm.sv
// mips_ctrl_fsm -- multi-cycle control FSM for a small MIPS subset.
//
// Accepts one instruction per valid/ready handshake, decodes it, drives
// ALU controls, waits for the ALU flags, optionally performs a memory
// access, then emits the write-back, branch, done or exception pulses.
//
// Ports
//   clk            rising-edge clock
//   reset          synchronous, active-high reset
//   instr_valid    instruction offered
//   instr_ready    FSM idle and able to accept (low while reset is high)
//   instr[31:0]    MIPS instruction word, captured on the handshake
//   alu_zero       ALU zero flag, valid one cycle after controls are presented
//   alu_overflow   ALU signed-overflow flag, same timing as alu_zero
//   alu_control    ALU operation code, held from EXEC until the next decode
//   shift_amount   shamt for sll/srl/sra, else 0
//   alu_src_imm    second ALU operand is the immediate
//   imm_zero_ext   immediate is zero-extended (andi/ori)
//   mem_read       load request, held until mem_ready
//   mem_write      store request, held until mem_ready
//   mem_ready      memory request completion
//   reg_write      one-cycle write-back pulse
//   branch_taken   one-cycle branch outcome pulse
//   done           one-cycle end-of-instruction pulse
//   exc_overflow   one-cycle arithmetic overflow trap pulse
//   exc_illegal    one-cycle illegal instruction pulse
//
// Configuration macro
//   MIPS_CTRL_OVF_TRAP_EN  when defined, add/sub/addi with alu_overflow=1
//                          trap to EXC instead of writing back.

module mips_ctrl_fsm (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  input  logic        alu_zero,
  input  logic        alu_overflow,
  output logic [3:0]  alu_control,
  output logic [4:0]  shift_amount,
  output logic        alu_src_imm,
  output logic        imm_zero_ext,
  output logic        mem_read,
  output logic        mem_write,
  input  logic        mem_ready,
  output logic        reg_write,
  output logic        branch_taken,
  output logic        done,
  output logic        exc_overflow,
  output logic        exc_illegal
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DECODE   = 3'd1,
    EXEC     = 3'd2,
    WAIT_ALU = 3'd3,
    MEM      = 3'd4,
    WB       = 3'd5,
    FIN      = 3'd6,
    EXC      = 3'd7
  } state_t;

  // Instruction class, decides the path taken after WAIT_ALU.
  typedef enum logic [2:0] {
    K_ALU = 3'd0,
    K_LW  = 3'd1,
    K_SW  = 3'd2,
    K_BEQ = 3'd3,
    K_BNE = 3'd4
  } kind_t;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b0110;
  localparam logic [3:0] ALU_LESS = 4'b1000;
  localparam logic [3:0] ALU_NOR  = 4'b1001;

  state_t      state_r;
  kind_t       kind_r;
  logic [31:0] instr_r;
  logic        ovf_chk_r;

  logic        dec_legal_s;
  logic [3:0]  dec_ctl_s;
  logic [4:0]  dec_shamt_s;
  logic        dec_imm_s;
  logic        dec_zext_s;
  kind_t       dec_kind_s;
  logic        dec_ovf_s;
  logic [5:0]  op_s;
  logic [5:0]  funct_s;

  assign instr_ready = (state_r == IDLE) && !reset;
  assign op_s        = instr_r[31:26];
  assign funct_s     = instr_r[5:0];

  // Decode of the captured instruction word.
  always_comb begin
    dec_legal_s = 1'b1;
    dec_ctl_s   = ALU_ADD;
    dec_shamt_s = 5'd0;
    dec_imm_s   = 1'b0;
    dec_zext_s  = 1'b0;
    dec_kind_s  = K_ALU;
    dec_ovf_s   = 1'b0;
    case (op_s)
      6'h00: begin
        case (funct_s)
          6'h20: begin dec_ctl_s = ALU_ADD; dec_ovf_s = 1'b1; end
          6'h22: begin dec_ctl_s = ALU_SUB; dec_ovf_s = 1'b1; end
          6'h24: dec_ctl_s = ALU_AND;
          6'h25: dec_ctl_s = ALU_OR;
          6'h27: dec_ctl_s = ALU_NOR;
          6'h00: begin dec_ctl_s = ALU_SLL; dec_shamt_s = instr_r[10:6]; end
          6'h02: begin dec_ctl_s = ALU_SRL; dec_shamt_s = instr_r[10:6]; end
          6'h03: begin dec_ctl_s = ALU_SRA; dec_shamt_s = instr_r[10:6]; end
          6'h2A: dec_ctl_s = ALU_LESS;
          default: dec_legal_s = 1'b0;
        endcase
      end
      6'h08: begin dec_ctl_s = ALU_ADD;  dec_imm_s = 1'b1; dec_ovf_s = 1'b1; end
      6'h0C: begin dec_ctl_s = ALU_AND;  dec_imm_s = 1'b1; dec_zext_s = 1'b1; end
      6'h0D: begin dec_ctl_s = ALU_OR;   dec_imm_s = 1'b1; dec_zext_s = 1'b1; end
      6'h0A: begin dec_ctl_s = ALU_LESS; dec_imm_s = 1'b1; end
      6'h23: begin dec_ctl_s = ALU_ADD;  dec_imm_s = 1'b1; dec_kind_s = K_LW; end
      6'h2B: begin dec_ctl_s = ALU_ADD;  dec_imm_s = 1'b1; dec_kind_s = K_SW; end
      6'h04: begin dec_ctl_s = ALU_SUB;  dec_kind_s = K_BEQ; end
      6'h05: begin dec_ctl_s = ALU_SUB;  dec_kind_s = K_BNE; end
      default: dec_legal_s = 1'b0;
    endcase
  end

  // Control FSM; every output is registered and set on entry to the state
  // in which it must be visible, so pulses line up with that state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      kind_r       <= K_ALU;
      instr_r      <= 32'd0;
      ovf_chk_r    <= 1'b0;
      alu_control  <= 4'd0;
      shift_amount <= 5'd0;
      alu_src_imm  <= 1'b0;
      imm_zero_ext <= 1'b0;
      mem_read     <= 1'b0;
      mem_write    <= 1'b0;
      reg_write    <= 1'b0;
      branch_taken <= 1'b0;
      done         <= 1'b0;
      exc_overflow <= 1'b0;
      exc_illegal  <= 1'b0;
    end else begin
      reg_write    <= 1'b0;
      branch_taken <= 1'b0;
      done         <= 1'b0;
      exc_overflow <= 1'b0;
      exc_illegal  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (instr_valid) begin
            instr_r <= instr;
            state_r <= DECODE;
          end else begin
            state_r <= IDLE;
          end
        end
        DECODE: begin
          if (dec_legal_s) begin
            alu_control  <= dec_ctl_s;
            shift_amount <= dec_shamt_s;
            alu_src_imm  <= dec_imm_s;
            imm_zero_ext <= dec_zext_s;
            kind_r       <= dec_kind_s;
            ovf_chk_r    <= dec_ovf_s;
            state_r      <= EXEC;
          end else begin
            exc_illegal <= 1'b1;
            done        <= 1'b1;
            state_r     <= EXC;
          end
        end
        EXEC: state_r <= WAIT_ALU;
        WAIT_ALU: begin
`ifdef MIPS_CTRL_OVF_TRAP_EN
          if (ovf_chk_r && alu_overflow) begin
            exc_overflow <= 1'b1;
            done         <= 1'b1;
            state_r      <= EXC;
          end else begin
`else
          // Overflow is not trapped: the wrapped result is written back.
          begin
`endif
            case (kind_r)
              K_LW: begin mem_read  <= 1'b1; state_r <= MEM; end
              K_SW: begin mem_write <= 1'b1; state_r <= MEM; end
              K_BEQ: begin
                branch_taken <= alu_zero;
                done         <= 1'b1;
                state_r      <= FIN;
              end
              K_BNE: begin
                branch_taken <= !alu_zero;
                done         <= 1'b1;
                state_r      <= FIN;
              end
              default: begin
                reg_write <= 1'b1;
                done      <= 1'b1;
                state_r   <= WB;
              end
            endcase
          end
        end
        MEM: begin
          if (mem_ready) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            done      <= 1'b1;
            if (kind_r == K_LW) begin
              reg_write <= 1'b1;
              state_r   <= WB;
            end else begin
              state_r <= FIN;
            end
          end else begin
            state_r <= MEM;
          end
        end
        WB:      state_r <= IDLE;
        FIN:     state_r <= IDLE;
        EXC:     state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mips_ctrl_fsm.md
MIPS_CTRL_FSM -- requirements
Module: mips_ctrl_fsm

Interface
REQ-001 SHALL: clk  input  1  rising-edge clock.
REQ-002 SHALL: reset  input  1  reset, synchronous, active-high.
REQ-003 SHALL: instr_valid / instr_ready  input / output  1 / 1  instruction handshake; transfer when both are high.
REQ-004 SHALL: instr  input  32  MIPS instruction word.
REQ-005 SHALL: alu_zero, alu_overflow  input  1 each  ALU flags, valid one cycle after operands and control are presented.
REQ-006 SHALL: alu_control  output  4  ADD=0000, SUB=0001, AND=0010, OR=0011, SLL=0100, SRL=0101, SRA=0110, GREATER=0111, LESS=1000, NOR=1001.
REQ-007 SHALL: shift_amount  output  5  shamt field.
REQ-008 SHALL: alu_src_imm, imm_zero_ext  output  1 each  immediate operand select; zero-extend rather than sign-extend.
REQ-009 SHALL: mem_read, mem_write  output  1 each  memory request; mem_ready  input  1  request completion.
REQ-010 SHALL: reg_write, branch_taken, done, exc_overflow, exc_illegal  output  1 each  single-cycle pulses.

Function
REQ-011 SHALL use states IDLE, DECODE, EXEC, WAIT_ALU, MEM, WB, FIN, EXC.
REQ-012 SHALL drive instr_ready = (state==IDLE) and not reset.
REQ-013 SHALL transition IDLE->DECODE on handshake and capture instr into an internal register; later changes on instr are ignored.
REQ-014 SHALL decode in DECODE; R-type (op 0x00) funct mapping: 0x20 add->ADD, 0x22 sub->SUB, 0x24->AND, 0x25->OR, 0x27->NOR, 0x00->SLL, 0x02->SRL, 0x03->SRA, 0x2A slt->LESS.
REQ-015 SHALL map I-type ops: 0x08 addi->ADD, 0x0C andi->AND (zero-ext), 0x0D ori->OR (zero-ext), 0x0A slti->LESS, 0x23 lw->ADD, 0x2B sw->ADD, 0x04 beq->SUB, 0x05 bne->SUB.
REQ-016 SHALL treat any other op/funct as illegal: DECODE->EXC.
REQ-017 SHALL hold alu_control, shift_amount, alu_src_imm and imm_zero_ext stable from EXEC through the end of the instruction; shift_amount=instr[10:6] for shifts, else 0.
REQ-018 SHALL assert alu_src_imm for addi, andi, ori, slti, lw and sw only.
REQ-019 SHALL go EXEC->WAIT_ALU unconditionally and sample alu_zero/alu_overflow in WAIT_ALU.
REQ-020 SHALL route WAIT_ALU to: MEM for lw/sw; FIN for beq/bne; WB for all other instructions (subject to REQ-032).
REQ-021 SHALL, in FIN for branches, pulse branch_taken = alu_zero (beq) or not alu_zero (bne).
REQ-022 SHALL hold mem_read (lw) or mem_write (sw) high in MEM until the cycle mem_ready=1; then go lw->WB, sw->FIN.
REQ-023 SHALL treat a mem_ready seen outside MEM as having no effect.
REQ-024 SHALL pulse reg_write in WB for every instruction except sw, beq and bne.
REQ-025 SHALL pulse done in WB, FIN and EXC; these states return to IDLE next cycle.
REQ-026 SHALL latency R-type/ALU-immediate: handshake at cycle N -> reg_write and done at cycle N+4.
REQ-027 SHALL, in EXC, pulse exc_illegal or exc_overflow, never assert reg_write, and issue no memory request.

Reset
REQ-028 SHALL, on reset high at a clock edge, go to IDLE from any state, including mid-MEM.
REQ-029 SHALL clear all registered outputs to 0 on reset, including alu_control=0000 and shift_amount=0; no pulse may be emitted in the following cycle.
REQ-030 SHALL force instr_ready low while reset is high; reset takes priority over a simultaneous handshake.

Configuration
REQ-031 SHALL use the macro MIPS_CTRL_OVF_TRAP_EN.
REQ-032 SHALL, with MIPS_CTRL_OVF_TRAP_EN defined, route add/sub/addi with alu_overflow=1 in WAIT_ALU to EXC, asserting exc_overflow and suppressing reg_write.
REQ-033 SHALL, without MIPS_CTRL_OVF_TRAP_EN, ignore alu_overflow, tie exc_overflow to 0 and write back the wrapped result.

Verification
REQ-034 SHALL cover: instr=0x012A4020 (add) accepted at cycle 0 -> alu_control=0000 from cycle 2, reg_write=done=1 at cycle 4, instr_ready=1 at cycle 5.
REQ-035 SHALL cover: instr=0x00031140 (sll) -> alu_control=0100, shift_amount=5, alu_src_imm=0, reg_write at cycle 4.
REQ-036 SHALL cover: instr=0x8C820004 (lw) with mem_ready delayed 3 cycles -> mem_read high for exactly 4 cycles, alu_src_imm=1, then reg_write pulse.
REQ-037 SHALL cover: beq with alu_zero=1 -> branch_taken=1 in FIN; bne with alu_zero=1 -> branch_taken=0; reg_write=0 in both cases.
REQ-038 SHALL cover: add with alu_overflow=1 -> with the macro, exc_overflow=1 and reg_write=0; without the macro, reg_write=1 and exc_overflow=0.
REQ-039 SHALL cover: op 0x3F -> exc_illegal and done at cycle 2; sw with reset asserted during MEM -> mem_write=0 next cycle, state IDLE, no done.
